cache_mem_arbiter: RTL and testbench

Sequencer that shares the single pipelined, multi-cycle main memory between the I-cache fill engine and the D-cache (miss fills plus write-through stores). It grants one requester at a time, issues a full 8-word block read burst or a single-word write, and steers returned words into the owning cache's data array with a word index. It sits between both caches and the memory model, below the pipeline stall logic that watches the cache busy signals.

---
 rtl/cache_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_cache_mem_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Shares one pipelined main memory between the I-cache fill engine and the D-cache
// (block fills plus write-through stores), steering returned words into the owning array.
module cache_mem_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_fill_req,
    input  logic [15:0] i_fill_addr,
    input  logic        d_fill_req,
    input  logic [15:0] d_fill_addr,
    input  logic        d_wr_req,
    input  logic [15:0] d_wr_addr,
    input  logic [15:0] d_wr_data,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    input  logic [15:0] mem_data_out,
    input  logic        mem_data_valid,
    output logic        i_fill_we,
    output logic        d_fill_we,
    output logic [2:0]  fill_word,
    output logic [15:0] fill_data,
    output logic        i_fill_done,
    output logic        d_fill_done,
    output logic        d_wr_ack,
    output logic        i_busy,
    output logic        d_busy
);

    typedef enum logic [1:0] {StIdle, StWrite, StFill} arbState_e;
    typedef enum logic {OwnerI = 1'b0, OwnerD = 1'b1} owner_e;

    localparam logic [3:0] BlockWords = 4'd8;
    localparam logic [3:0] LastWord   = BlockWords - 4'd1;

    arbState_e   state, stateNext;
    owner_e      owner, lastFillOwner, grantOwner;
    logic [11:0] base;
    logic [3:0]  issCnt, rcvCnt;
    logic        startFill, issuing, fillValid, lastBeat;

    // Byte offset within a block never reaches the memory; only base is latched.
    logic unusedAddrBits;
    assign unusedAddrBits = ^{i_fill_addr[3:0], d_fill_addr[3:0]};

    assign issuing   = (state == StFill) && (issCnt < BlockWords);
    assign fillValid = (state == StFill) && mem_data_valid;
    assign lastBeat  = fillValid && (rcvCnt == LastWord);

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        stateNext  = state;
        startFill  = 1'b0;
        grantOwner = OwnerI;
        case (state)
            StIdle: begin
                if (d_wr_req) begin
                    stateNext = StWrite;
                end else if (i_fill_req || d_fill_req) begin
                    startFill = 1'b1;
                    stateNext = StFill;
                    // On a tie the owner that did not fill last wins.
                    if (d_fill_req && (!i_fill_req || lastFillOwner == OwnerI))
                        grantOwner = OwnerD;
                end
            end
            StWrite: stateNext = StIdle;
            StFill:  if (lastBeat) stateNext = StIdle;
            default: stateNext = StIdle;
        endcase
    end

    always_comb begin
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        i_fill_we   = 1'b0;
        d_fill_we   = 1'b0;
        fill_word   = '0;
        fill_data   = '0;
        i_fill_done = 1'b0;
        d_fill_done = 1'b0;
        d_wr_ack    = 1'b0;

        if (state == StWrite) begin
            mem_en      = 1'b1;
            mem_wr      = 1'b1;
            mem_addr    = d_wr_addr;
            mem_data_in = d_wr_data;
            d_wr_ack    = 1'b1;
        end

        if (issuing) begin
            mem_en   = 1'b1;
            mem_addr = {base, issCnt[2:0], 1'b0};
        end

        if (fillValid) begin
            fill_word = rcvCnt[2:0];
            fill_data = mem_data_out;
            if (owner == OwnerI) begin
                i_fill_we   = 1'b1;
                i_fill_done = lastBeat;
            end else begin
                d_fill_we   = 1'b1;
                d_fill_done = lastBeat;
            end
        end

        i_busy = (state == StFill) && (owner == OwnerI);
        d_busy = (state == StWrite) || ((state == StFill) && (owner == OwnerD));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= StIdle;
            owner         <= OwnerI;
            lastFillOwner <= OwnerI;
            base          <= '0;
            issCnt        <= '0;
            rcvCnt        <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= stateNext;
            if (startFill) begin
                owner         <= grantOwner;
                lastFillOwner <= grantOwner;
                base          <= (grantOwner == OwnerD) ? d_fill_addr[15:4] : i_fill_addr[15:4];
                issCnt        <= '0;
                rcvCnt        <= '0;
            end else begin
                if (issuing)   issCnt <= issCnt + 4'd1;
                if (fillValid) rcvCnt <= rcvCnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter with a 4-cycle pipelined memory model.
module tb_cache_mem_arbiter;

    localparam int MemLatency = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_fill_req, d_fill_req, d_wr_req;
    logic [15:0] i_fill_addr, d_fill_addr, d_wr_addr, d_wr_data;
    logic        mem_en, mem_wr, mem_data_valid;
    logic [15:0] mem_addr, mem_data_in, mem_data_out, fill_data;
    logic        i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack, i_busy, d_busy;
    logic [2:0]  fill_word;

    int passCount  = 0;
    int checkCount = 0;

    // Memory model: read issued in cycle n returns in cycle n+MemLatency.
    logic [MemLatency-1:0] pipeV = '0;
    logic [15:0]           pipeA [MemLatency];
    logic                  extraValid = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        pipeV    <= {pipeV[MemLatency-2:0], mem_en && !mem_wr};
        pipeA[0] <= mem_addr;
        for (int k = 1; k < MemLatency; k++) pipeA[k] <= pipeA[k-1];
    end

    assign mem_data_valid = pipeV[MemLatency-1] | extraValid;
    assign mem_data_out   = pipeA[MemLatency-1] ^ 16'h5A3C;

    cache_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_fill_req(i_fill_req), .i_fill_addr(i_fill_addr),
        .d_fill_req(d_fill_req), .d_fill_addr(d_fill_addr),
        .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid),
        .i_fill_we(i_fill_we), .d_fill_we(d_fill_we), .fill_word(fill_word),
        .fill_data(fill_data), .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
        .d_wr_ack(d_wr_ack), .i_busy(i_busy), .d_busy(d_busy)
    );

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, " mem_en"}, 16'(mem_en), 16'h0);
        check({tag, " mem_wr"}, 16'(mem_wr), 16'h0);
        check({tag, " mem_addr"}, mem_addr, 16'h0);
        check({tag, " mem_data_in"}, mem_data_in, 16'h0);
        check({tag, " fill_we"}, 16'({i_fill_we, d_fill_we}), 16'h0);
        check({tag, " fill_word"}, 16'(fill_word), 16'h0);
        check({tag, " fill_data"}, fill_data, 16'h0);
        check({tag, " done/ack"}, 16'({i_fill_done, d_fill_done, d_wr_ack}), 16'h0);
        check({tag, " busy"}, 16'({i_busy, d_busy}), 16'h0);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Called in the cycle the request is visible (cycle 0); walks cycles 1..13 of the fill.
    task automatic runFill(input bit ownerI, input logic [15:0] reqAddr, input bit keepReq, input int wrAt);
        logic [2:0]  w;
        logic [15:0] expAddr;
        string       t;
        for (int c = 1; c <= 13; c++) begin
            nextCycle();
            if (c == wrAt) begin
                d_wr_req  = 1'b1;
                d_wr_addr = 16'h0A0A;
                d_wr_data = 16'h1357;
            end
            if (c == 13) begin
                if (ownerI) i_fill_req = keepReq;
                else        d_fill_req = keepReq;
            end
            #3;
            t = $sformatf("fill %s@%h c%0d", ownerI ? "I" : "D", reqAddr, c);
            if (c <= 12) begin
                check({t, " mem_en"}, 16'(mem_en), 16'(c <= 8));
                check({t, " mem_wr"}, 16'(mem_wr), 16'h0);
                if (c <= 8) begin
                    w = 3'(c - 1);
                    expAddr = {reqAddr[15:4], w, 1'b0};
                    check({t, " mem_addr"}, mem_addr, expAddr);
                end
                check({t, " owner_we"}, 16'(ownerI ? i_fill_we : d_fill_we), 16'(c >= 5));
                check({t, " other_we"}, 16'(ownerI ? d_fill_we : i_fill_we), 16'h0);
                if (c >= 5) begin
                    w = 3'(c - 5);
                    check({t, " fill_word"}, 16'(fill_word), 16'(w));
                    check({t, " fill_data"}, fill_data, {reqAddr[15:4], w, 1'b0} ^ 16'h5A3C);
                end
                check({t, " owner_done"}, 16'(ownerI ? i_fill_done : d_fill_done), 16'(c == 12));
                check({t, " other_done"}, 16'(ownerI ? d_fill_done : i_fill_done), 16'h0);
                check({t, " busy"}, 16'({i_busy, d_busy}), ownerI ? 16'h2 : 16'h1);
                check({t, " d_wr_ack"}, 16'(d_wr_ack), 16'h0);
            end else begin
                check({t, " idle mem_en"}, 16'(mem_en), 16'h0);
                check({t, " idle busy"}, 16'({i_busy, d_busy}), 16'h0);
                check({t, " idle ack"}, 16'(d_wr_ack), 16'h0);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        i_fill_req  = 1'b0;
        d_fill_req  = 1'b0;
        d_wr_req    = 1'b0;
        i_fill_addr = '0;
        d_fill_addr = '0;
        d_wr_addr   = '0;
        d_wr_data   = '0;
        #2;
        checkAllZero("reset");
        nextCycle();
        nextCycle();
        rst_n = 1'b1;

        // Single I fill at 0x1234.
        nextCycle();
        i_fill_addr = 16'h1234;
        i_fill_req  = 1'b1;
        runFill(1'b1, 16'h1234, 1'b0, 0);

        // Store and both fills raised together: write, then D fill, then I fill.
        nextCycle();
        d_wr_req    = 1'b1;
        d_wr_addr   = 16'h0040;
        d_wr_data   = 16'hBEEF;
        d_fill_addr = 16'h2000;
        d_fill_req  = 1'b1;
        i_fill_addr = 16'h3000;
        i_fill_req  = 1'b1;
        nextCycle();
        #3;
        check("write mem_en", 16'(mem_en), 16'h1);
        check("write mem_wr", 16'(mem_wr), 16'h1);
        check("write mem_addr", mem_addr, 16'h0040);
        check("write mem_data_in", mem_data_in, 16'hBEEF);
        check("write ack", 16'(d_wr_ack), 16'h1);
        check("write busy", 16'({i_busy, d_busy}), 16'h1);
        nextCycle();
        d_wr_req = 1'b0;
        #3;
        check("post-write ack", 16'(d_wr_ack), 16'h0);
        check("post-write mem_en", 16'(mem_en), 16'h0);
        check("post-write busy", 16'({i_busy, d_busy}), 16'h0);
        runFill(1'b0, 16'h2000, 1'b0, 0);
        runFill(1'b1, 16'h3000, 1'b0, 0);

        // Both fills re-requested after every done: grants alternate D, I, D, I.
        nextCycle();
        d_fill_addr = 16'h4010;
        i_fill_addr = 16'h5020;
        d_fill_req  = 1'b1;
        i_fill_req  = 1'b1;
        runFill(1'b0, 16'h4010, 1'b1, 0);
        runFill(1'b1, 16'h5020, 1'b1, 0);
        runFill(1'b0, 16'h4010, 1'b1, 0);
        runFill(1'b1, 16'h5020, 1'b0, 0);
        d_fill_req = 1'b0;

        // Store raised mid I fill waits until the fill finishes.
        nextCycle();
        i_fill_addr = 16'h1234;
        i_fill_req  = 1'b1;
        runFill(1'b1, 16'h1234, 1'b0, 3);
        nextCycle();
        #3;
        check("late write mem_wr", 16'(mem_wr), 16'h1);
        check("late write mem_addr", mem_addr, 16'h0A0A);
        check("late write mem_data_in", mem_data_in, 16'h1357);
        check("late write ack", 16'(d_wr_ack), 16'h1);
        check("late write busy", 16'({i_busy, d_busy}), 16'h1);
        nextCycle();
        d_wr_req = 1'b0;
        #3;
        check("late post-write ack", 16'(d_wr_ack), 16'h0);
        check("late post-write busy", 16'(d_busy), 16'h0);

        // Asynchronous reset in cycle 6 of a fill; later valids must be ignored.
        nextCycle();
        i_fill_addr = 16'h7770;
        i_fill_req  = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            nextCycle();
            #3;
            check($sformatf("rst-fill c%0d mem_en", c), 16'(mem_en), 16'h1);
        end
        nextCycle();
        #1;
        check("rst-fill c6 mem_addr", mem_addr, 16'h777A);
        rst_n      = 1'b0;
        i_fill_req = 1'b0;
        #1;
        checkAllZero("mid-fill reset");
        for (int c = 7; c <= 12; c++) begin
            nextCycle();
            if (c == 7) rst_n = 1'b1;
            extraValid = 1'b1;
            #3;
            check($sformatf("post-rst c%0d we", c), 16'({i_fill_we, d_fill_we}), 16'h0);
            check($sformatf("post-rst c%0d done", c), 16'({i_fill_done, d_fill_done}), 16'h0);
            check($sformatf("post-rst c%0d mem_en", c), 16'(mem_en), 16'h0);
            check($sformatf("post-rst c%0d busy", c), 16'({i_busy, d_busy}), 16'h0);
        end
        nextCycle();
        extraValid = 1'b0;

        // Top block of the address space: no wrap past 0xFFFE.
        nextCycle();
        d_fill_addr = 16'hFFF8;
        d_fill_req  = 1'b1;
        runFill(1'b0, 16'hFFF8, 1'b0, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
